// File: rtl/alu_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Shared opcode, state and width definitions for the iterative ALU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    localparam logic OP_ADD        = 1'b1;
    localparam logic OP_SUB        = 1'b0;
    localparam int   WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_slice.sv
//==============================================================================
// Module      : alu_slice
// Description : One slice of the iterative ALU: adder with carry and equality.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_slice #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [SLICE_W-1:0] b_eff,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               eq
);

    logic [SLICE_W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
    assign sum    = w_full[SLICE_W-1:0];
    assign cout   = w_full[SLICE_W];
    // Equality uses the original operand, never the inverted one.
    assign eq     = (a == b);

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
//==============================================================================
// Module      : alu_iter
// Description : Multi-cycle add/subtract/compare unit, SLICE_W bits per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int SLICE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             eq,
    output logic             cout
);

    localparam int NSLICE  = WIDTH / SLICE_W;
    localparam int c_cnt_w = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
        $error("alu_iter: WIDTH must be a multiple of SLICE_W");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_b_eff;
    logic [WIDTH-1:0]   r_out;
    logic [c_cnt_w-1:0] r_count;
    logic               r_carry;
    logic               r_eq_acc;
    logic               r_eq;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_accept;

    logic [SLICE_W-1:0] w_a_sl  [NSLICE];
    logic [SLICE_W-1:0] w_b_sl  [NSLICE];
    logic [SLICE_W-1:0] w_be_sl [NSLICE];
    logic [SLICE_W-1:0] w_sum;
    logic               w_c;
    logic               w_sl_eq;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_split
        assign w_a_sl[gi]  = r_a[gi*SLICE_W +: SLICE_W];
        assign w_b_sl[gi]  = r_b[gi*SLICE_W +: SLICE_W];
        assign w_be_sl[gi] = r_b_eff[gi*SLICE_W +: SLICE_W];
    end

    // A single slice engine, fed by the slice selected by the counter.
    alu_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a     (w_a_sl[r_count]),
        .b     (w_b_sl[r_count]),
        .b_eff (w_be_sl[r_count]),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_c),
        .eq    (w_sl_eq)
    );

    assign w_accept = in_valid & r_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = CALC;
            CALC:    if (r_count == c_last) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_b_eff     <= '0;
            r_out       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_eq_acc    <= 1'b0;
            r_eq        <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_b_eff  <= (op == OP_ADD) ? b : ~b;
                r_carry  <= (op == OP_SUB);
                r_eq_acc <= 1'b1;
                r_count  <= '0;
            end
            if (r_state == CALC) begin
                r_carry  <= w_c;
                r_eq_acc <= r_eq_acc & w_sl_eq;
                r_count  <= r_count + c_cnt_w'(1);
                for (int i = 0; i < NSLICE; i++) begin
                    if (r_count == c_cnt_w'(i)) begin
                        r_out[i*SLICE_W +: SLICE_W] <= w_sum;
                    end
                end
                if (r_count == c_last) begin
                    r_eq   <= r_eq_acc & w_sl_eq;
                    r_cout <= w_c;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign eq        = r_eq;
    assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
//==============================================================================
// Module      : tb_alu_iter
// Description : Self-checking bench for alu_iter against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] tb_a;
    logic [63:0] tb_b;
    logic        tb_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;
    logic        deq;
    logic        dcout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_iter #(
        .WIDTH   (64),
        .SLICE_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (tb_a),
        .b         (tb_b),
        .op        (tb_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .eq        (deq),
        .cout      (dcout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Reference: {eq, cout, out} from plain 65-bit arithmetic.
    function automatic logic [65:0] ref_model(input logic [63:0] x, input logic [63:0] y,
                                              input logic add);
        logic [64:0] r;
        if (add) r = {1'b0, x} + {1'b0, y};
        else     r = {1'b0, x} - {1'b0, y};
        return {x == y, add ? r[64] : ~r[64], r[63:0]};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL in_ready_timeout: got in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic start_op(input logic [63:0] x, input logic [63:0] y, input logic o);
        wait_ready();
        tb_a = x; tb_b = y; tb_op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tb_a = rand64(); tb_b = rand64(); tb_op = $urandom_range(0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            vectors++; miscompares++;
            $display("FAIL out_valid_timeout: got out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tb_a = '0; tb_b = '0; tb_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        vectors++; if (dout !== 64'h0) begin miscompares++; $display("FAIL reset_out: got %h required 0", dout); end
        vectors++; if (deq !== 1'b0) begin miscompares++; $display("FAIL reset_eq: got %b required 0", deq); end
        vectors++; if (dcout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b required 0", dcout); end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [63:0] va[5], vb[5], vo[5];
        logic        vop[5], veq[5], vc[5];
        int lat;
        va[0] = 64'h0000_FFFF_FFFF_00FF; vb[0] = 64'h0000_FFFF_FFFF_FF00; vop[0] = 1'b1;
        vo[0] = 64'h0001_FFFF_FFFE_FFFF; veq[0] = 1'b0; vc[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF; vop[1] = 1'b1;
        vo[1] = 64'hFFFF_FFFF_FFFF_FFFE; veq[1] = 1'b1; vc[1] = 1'b1;
        va[2] = 64'h0000_1111_0000_2222; vb[2] = 64'h0000_1111_0000_2222; vop[2] = 1'b1;
        vo[2] = 64'h0000_2222_0000_4444; veq[2] = 1'b1; vc[2] = 1'b0;
        va[3] = 64'h0000_1111_0000_2222; vb[3] = 64'h0000_1111_0000_2222; vop[3] = 1'b0;
        vo[3] = 64'h0;                   veq[3] = 1'b1; vc[3] = 1'b1;
        va[4] = 64'h0;                   vb[4] = 64'h1;                   vop[4] = 1'b0;
        vo[4] = 64'hFFFF_FFFF_FFFF_FFFF; veq[4] = 1'b0; vc[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vop[i]);
            wait_valid(lat);
            vectors++; if (lat !== 4) begin miscompares++; $display("FAIL dir%0d_latency: got %0d required 4", i, lat); end
            vectors++; if (dout !== vo[i]) begin miscompares++; $display("FAIL dir%0d_out: got %h required %h", i, dout, vo[i]); end
            vectors++; if (deq !== veq[i]) begin miscompares++; $display("FAIL dir%0d_eq: got %b required %b", i, deq, veq[i]); end
            vectors++; if (dcout !== vc[i]) begin miscompares++; $display("FAIL dir%0d_cout: got %b required %b", i, dcout, vc[i]); end
            release_out();
            vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_release: got out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] x, y;
        logic        o;
        logic [65:0] exp;
        int lat;
        x = rand64(); y = rand64(); o = $urandom_range(0, 1);
        exp = ref_model(x, y, o);
        start_op(x, y, o);
        wait_valid(lat);
        // New operands offered while busy must be ignored.
        in_valid = 1'b1; tb_a = rand64(); tb_b = rand64();
        for (int i = 0; i < 10; i++) begin
            vectors++; if (dout !== exp[63:0]) begin miscompares++; $display("FAIL bp%0d_out: got %h required %h", i, dout, exp[63:0]); end
            vectors++; if (deq !== exp[65] || dcout !== exp[64]) begin
                miscompares++;
                $display("FAIL bp%0d_flags: got eq=%b cout=%b required %b/%b", i, deq, dcout, exp[65], exp[64]);
            end
            vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp%0d_hs: got in_ready=%b out_valid=%b required 0/1", i, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_out();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] x, y;
        logic        o, early;
        logic [65:0] exp;
        int lat;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin x = rand64(); y = rand64(); end
                1: begin x = rand64(); y = x; end
                2: begin x = 64'($urandom_range(0, 15)); y = 64'($urandom_range(0, 15)); end
                default: begin x = ~64'($urandom_range(0, 3)); y = ~64'($urandom_range(0, 3)); end
            endcase
            o = $urandom_range(0, 1);
            exp = ref_model(x, y, o);
            start_op(x, y, o);
            early = $urandom_range(0, 1);
            out_ready = early;
            wait_valid(lat);
            vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d required 4", i, lat); end
            vectors++; if (dout !== exp[63:0]) begin miscompares++; $display("FAIL rnd%0d_out: got %h required %h", i, dout, exp[63:0]); end
            vectors++; if (deq !== exp[65]) begin miscompares++; $display("FAIL rnd%0d_eq: got %b required %b", i, deq, exp[65]); end
            vectors++; if (dcout !== exp[64]) begin miscompares++; $display("FAIL rnd%0d_cout: got %b required %b", i, dcout, exp[64]); end
            if (!early) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            release_out();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_release: got out_valid=%b required 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] x, y;
        logic        o;
        logic [65:0] exp;
        int lat, last_acc, acc;
        out_ready = 1'b1;
        x = rand64(); y = rand64(); o = $urandom_range(0, 1);
        last_acc = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            tb_a = x; tb_b = y; tb_op = o; in_valid = 1'b1;
            exp = ref_model(x, y, o);
            @(posedge clk); #1;
            acc = cyc;
            if (i > 0) begin
                vectors++; if (acc - last_acc !== 6) begin
                    miscompares++;
                    $display("FAIL b2b%0d_gap: got %0d cycles required 6", i, acc - last_acc);
                end
            end
            last_acc = acc;
            x = rand64(); y = rand64(); o = $urandom_range(0, 1);
            tb_a = x; tb_b = y; tb_op = o;
            wait_valid(lat);
            vectors++; if (dout !== exp[63:0] || deq !== exp[65] || dcout !== exp[64]) begin
                miscompares++;
                $display("FAIL b2b%0d_result: got %h/%b/%b required %h/%b/%b", i, dout, deq, dcout, exp[63:0], exp[65], exp[64]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_ready();
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] x, y;
        logic [65:0] exp;
        int lat;
        x = rand64(); y = rand64();
        start_op(x, y, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_hs: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        vectors++; if (dout !== 64'h0 || deq !== 1'b0 || dcout !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h/%b/%b required 0/0/0", dout, deq, dcout);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_result: got out_valid=%b required 0", out_valid); end
        x = rand64(); y = rand64();
        exp = ref_model(x, y, 1'b0);
        start_op(x, y, 1'b0);
        wait_valid(lat);
        vectors++; if (dout !== exp[63:0] || deq !== exp[65] || dcout !== exp[64]) begin
            miscompares++;
            $display("FAIL midrst_next: got %h/%b/%b required %h/%b/%b", dout, deq, dcout, exp[63:0], exp[65], exp[64]);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
